// File: rtl/register_read_stage_pipe.sv
// Register read stage: NUM_REGS x DATA_W regfile (1W/2R, write-first bypass, imm override on op2)
// feeding a one-entry valid/ready output register with flush. REGREAD_HELD_REFRESH_EN enables held-operand refresh.
module register_read_stage_pipe #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int IDX_W       = $clog2(NUM_REGS),
  parameter int CTRL_W      = 7,
  parameter int IMM_SEL_BIT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] imm,
  input  logic [IDX_W-1:0]  src1_idx,
  input  logic [IDX_W-1:0]  src2_idx,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] reg1_read,
  output logic [DATA_W-1:0] reg2_read,
  output logic [CTRL_W-1:0] out_ctrl
);

  typedef struct packed {
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] op1, op2;
  logic              wr_en, capture, imm_sel;
  entry_t            ent;

  assign wr_en    = we && idx_ok(widx);
  assign imm_sel  = ctrl[IMM_SEL_BIT];
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[widx] <= wdata;
    end
  end

  // Write-first: a same-edge writeback is visible to the operand being captured.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (idx_ok(src1_idx)) op1 = (wr_en && widx == src1_idx) ? wdata : rf[src1_idx];
    if (imm_sel)               op2 = imm;
    else if (idx_ok(src2_idx)) op2 = (wr_en && widx == src2_idx) ? wdata : rf[src2_idx];
  end

`ifdef REGREAD_HELD_REFRESH_EN
  logic [IDX_W-1:0] held_s1, held_s2;
  logic             held_isel;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ent       <= '0;
`ifdef REGREAD_HELD_REFRESH_EN
      held_s1   <= '0;
      held_s2   <= '0;
      held_isel <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      ent       <= '{r1: op1, r2: op2, ctrl: ctrl};
`ifdef REGREAD_HELD_REFRESH_EN
      held_s1   <= src1_idx;
      held_s2   <= src2_idx;
      held_isel <= imm_sel;
`endif
    end else if (out_valid && !out_ready) begin
`ifdef REGREAD_HELD_REFRESH_EN
      // Stalled operands track late writebacks to their source registers.
      if (wr_en && widx == held_s1)               ent.r1 <= wdata;
      if (wr_en && !held_isel && widx == held_s2) ent.r2 <= wdata;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign reg1_read = ent.r1;
  assign reg2_read = ent.r2;
  assign out_ctrl  = ent.ctrl;

endmodule

// File: tb/tb_register_read_stage_pipe.sv
// Scoreboard bench for register_read_stage_pipe: directed scenarios then random traffic
// against a queue/array reference model. Honours REGREAD_HELD_REFRESH_EN like the design.
module tb_register_read_stage_pipe;
  localparam int DATA_W = 32, NUM_REGS = 8, IDX_W = 3, CTRL_W = 7, ISB = 6;

  logic              clk = 1'b0, rst = 1'b0;
  logic [CTRL_W-1:0] ctrl = '0, out_ctrl;
  logic [DATA_W-1:0] imm = '0, wdata = '0, reg1_read, reg2_read;
  logic [IDX_W-1:0]  src1_idx = '0, src2_idx = '0, widx = '0;
  logic              in_valid = 1'b0, in_ready, we = 1'b0, flush = 1'b0, out_valid, out_ready = 1'b0;

  register_read_stage_pipe #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W),
                             .CTRL_W(CTRL_W), .IMM_SEL_BIT(ISB)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .imm(imm), .src1_idx(src1_idx), .src2_idx(src2_idx),
    .in_valid(in_valid), .in_ready(in_ready), .we(we), .widx(widx), .wdata(wdata),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg1_read(reg1_read), .reg2_read(reg2_read), .out_ctrl(out_ctrl));

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] r1, r2;
    logic [CTRL_W-1:0] ctrl;
    int                s1, s2;
    bit                isel;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] mrf [NUM_REGS];
  int                n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one edge of the stage, applied just after it happens (inputs still stable).
  task automatic model_edge();
    bit   rdy;
    exp_t e;
    rdy = (q.size() == 0);  // a held entry with out_ready was already popped by the monitor
    if (q.size() != 0) begin
      if (flush) void'(q.pop_front());
`ifdef REGREAD_HELD_REFRESH_EN
      else begin
        e = q[0];
        if (we && int'(widx) == e.s1) e.r1 = wdata;
        if (we && !e.isel && int'(widx) == e.s2) e.r2 = wdata;
        q[0] = e;
      end
`endif
    end
    if (in_valid && rdy && !flush) begin
      e.s1 = int'(src1_idx); e.s2 = int'(src2_idx); e.isel = ctrl[ISB]; e.ctrl = ctrl;
      e.r1 = (we && widx == src1_idx) ? wdata : mrf[e.s1];
      e.r2 = e.isel ? imm : ((we && widx == src2_idx) ? wdata : mrf[e.s2]);
      q.push_back(e);
    end
    if (we) mrf[int'(widx)] = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input int s1, input int s2, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] im);
    in_valid = 1'b1; src1_idx = s1[IDX_W-1:0]; src2_idx = s2[IDX_W-1:0]; ctrl = c; imm = im;
  endtask

  task automatic wr(input bit en, input int i, input logic [DATA_W-1:0] d);
    we = en; widx = i[IDX_W-1:0]; wdata = d;
  endtask

  // Monitor: compares presented entry against scoreboard head; pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, (q.size() == 0) || out_ready);
      if (out_valid && q.size() != 0) begin
        chk("reg1_read", reg1_read, q[0].r1);
        chk("reg2_read", reg2_read, q[0].r2);
        chk("out_ctrl", out_ctrl, q[0].ctrl);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mrf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg1", reg1_read, 0);
    chk("rst_reg2", reg2_read, 0);
    chk("rst_ctrl", out_ctrl, 0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: read after reset
    out_ready = 1'b1;
    issue(3, 5, '0, '0); tick();
    in_valid = 1'b0; tick();

    // 2: writes, register read, immediate
    wr(1, 0, 32'hAAAA_AAAA); tick();
    wr(1, 1, 32'hBBBB_BBBB); tick();
    wr(0, 0, '0);
    issue(0, 1, '0, '0); tick();
    issue(0, 1, 7'b1000000, 32'hCAFE_BABE); tick();
    in_valid = 1'b0; tick();

    // 3: same-edge bypass
    wr(1, 2, 32'h1234_5678); issue(2, 0, '0, '0); tick();
    wr(0, 0, '0); in_valid = 1'b0; tick();

    // 4: back-pressure then back-to-back drain/capture
    out_ready = 1'b0;
    issue(0, 1, 7'h05, '0); tick();
    for (int i = 0; i < 3; i++) begin issue(i + 2, i, 7'h10, '0); tick(); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin issue(i, 7 - i, 7'(i + 1), '0); tick(); end
    in_valid = 1'b0; tick();

    // 5: flush beats capture and hold
    out_ready = 1'b0;
    issue(1, 2, 7'h11, '0); tick();
    flush = 1'b1; issue(0, 0, 7'h22, '0); tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);

    // 6: late writeback to a held source
    out_ready = 1'b1;
    wr(1, 4, 32'h0000_0011); tick();
    wr(0, 0, '0); out_ready = 1'b0;
    issue(4, 4, 7'b1000000, 32'h0000_0099); tick();
    in_valid = 1'b0; wr(1, 4, 32'h0000_0022); tick();
    wr(0, 0, '0);
    @(negedge clk);
`ifdef REGREAD_HELD_REFRESH_EN
    chk("refresh_reg1", reg1_read, 32'h0000_0022);
`else
    chk("frozen_reg1", reg1_read, 32'h0000_0011);
`endif
    chk("imm_not_refreshed", reg2_read, 32'h0000_0099);
    out_ready = 1'b1; tick(); tick();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      src1_idx  = IDX_W'($urandom_range(0, NUM_REGS - 1));
      src2_idx  = IDX_W'($urandom_range(0, NUM_REGS - 1));
      ctrl      = CTRL_W'($urandom);
      imm       = $urandom;
      wr($urandom_range(0, 1) == 1, $urandom_range(0, NUM_REGS - 1), $urandom);
      tick();
    end

    // Reset while a stalled entry is held
    flush = 1'b0; wr(0, 0, '0); out_ready = 1'b0;
    issue(2, 3, 7'h33, '0); tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_reg1", reg1_read, 0);
    q.delete();
    for (int i = 0; i < NUM_REGS; i++) mrf[i] = '0;
    @(posedge clk); #1 rst = 1'b1;
    out_ready = 1'b1;
    issue(2, 3, 7'h01, '0); tick();
    in_valid = 1'b0; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/register_read_stage_pipe.md
Name: register_read_stage_pipe

Overview:
Parametrised successor to the single-cycle register read stage. It holds a NUM_REGS x DATA_W register file with one write port and two read ports, and supports an immediate override on operand 2. Write-to-read bypass is included. Operands are registered into a one-entry output pipeline register with a valid/ready handshake and a flush, so the stage sits between decode and execute and can absorb execute-side stalls.

Parameters:
DATA_W, 32, register and immediate width
NUM_REGS, 8, number of architectural registers
IDX_W, $clog2(NUM_REGS), register index width
CTRL_W, 7, width of the decode control word carried through
IMM_SEL_BIT, 6, ctrl bit that selects imm instead of register for operand 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ctrl  in  CTRL_W  decode control word
imm  in  DATA_W  decoded immediate
src1_idx  in  IDX_W  operand 1 register index
src2_idx  in  IDX_W  operand 2 register index
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept this cycle
we  in  1  writeback enable
widx  in  IDX_W  writeback index
wdata  in  DATA_W  writeback data
flush  in  1  synchronous kill of the held entry
out_valid  out  1  output entry valid
out_ready  in  1  execute accepts the entry
reg1_read  out  DATA_W  registered operand 1
reg2_read  out  DATA_W  registered operand 2 (register or imm)
out_ctrl  out  CTRL_W  registered ctrl

Behaviour:
- Reset (rst=0, asynchronous): all register-file entries are 0. out_valid=0. reg1_read, reg2_read and out_ctrl are 0. Internal held indices are 0.
- Write port: on posedge with we=1, regfile[widx] <= wdata. Writes are independent of the handshake and of flush. A widx >= NUM_REGS is ignored.
- Combinational read with bypass (write-first): op1 = (we && widx==src1_idx) ? wdata : regfile[src1_idx]. op2 is formed the same way from src2_idx. If ctrl[IMM_SEL_BIT]=1, op2 = imm and bypass is not applied. A source index >= NUM_REGS reads 0.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Capture: on posedge with in_valid && in_ready && !flush, the stage registers op1, op2 and ctrl, registers src1_idx/src2_idx and the imm-select bit internally, and sets out_valid=1. The latency is 1 cycle from acceptance to out_valid.
- Drain: out_valid && out_ready with no new capture -> out_valid=0 next cycle. Simultaneous drain and capture -> new entry next cycle, no bubble.
- Hold: out_valid && !out_ready -> all outputs stable (except the optional refresh below).
- Flush: on posedge with flush=1, out_valid <= 0 and any capture that cycle is discarded. Flush has priority over capture and hold. Data outputs may retain stale values.
- Reset asserted mid-stall: the entry is lost, out_valid=0 immediately and asynchronously.
- No internal state machine beyond the valid bit. There are two states, EMPTY and FULL:
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on drain without capture, or on flush.
  - FULL -> FULL on hold, or on drain with capture.

Optional Feature:
Macro: REGREAD_HELD_REFRESH_EN.
- Defined: while FULL, a posedge write with we=1 and widx == held src1 idx updates reg1_read to wdata in the same edge. The same applies to operand 2 if widx == held src2 idx and its imm-select bit is 0. This keeps stalled operands coherent with late writebacks. Refresh applies on hold edges only; a capture on the same edge wins, and capture already bypasses the write.
- Undefined: held outputs are frozen until drained or flushed. Software or the hazard unit must guarantee that no writes hit held sources.

Test Plan:
1. Reset then read: rst=0 for 2 cycles, release. Capture src1=3, src2=5, ctrl=0 -> next cycle out_valid=1, reg1_read=0, reg2_read=0.
2. Write/read and immediate: write R0=AAAA_AAAA, R1=BBBB_BBBB. Capture src1=0, src2=1, ctrl=0 -> AAAA_AAAA / BBBB_BBBB. Then capture with ctrl=7'b1000000 and imm=CAFE_BABE -> reg1=AAAA_AAAA, reg2=CAFE_BABE.
3. Bypass: same cycle we=1, widx=2, wdata=1234_5678, capture src1=2 -> reg1_read=1234_5678 next cycle.
4. Back-pressure: out_ready=0 with in_valid=1 for 3 cycles -> in_ready=0, outputs unchanged, exactly one entry. Raise out_ready -> back-to-back captures with no bubble, in_ready=1.
5. Flush priority: FULL with out_ready=0; assert flush together with in_valid=1 -> out_valid=0 next cycle, in_ready=1, new instruction not captured.
6. Refresh (macro on/off): hold entry src1=4 (R4=0000_0011). Write R4=0000_0022 during the stall -> reg1_read=0000_0022 with the macro defined, 0000_0011 without it. Operand 2 with imm select is never refreshed.
